// File: rtl/mem_arb.sv
// mem_arb -- shared-memory arbiter and line-transfer sequencer.
//
// The I-cache and D-cache miss paths share one single-ported backing memory.
// Each request moves one 4-word line. Requests are arbitrated round-robin in
// IDLE, then four word accesses are issued back to back. Read data returns
// through a MEM_LAT-deep tag pipeline to the winning side; write data is
// pulled from the D-cache one word at a time through dwidx/dwdata.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ireq, iaddr           I-cache line read request and line address
//   igrant                request accepted (iaddr sampled this cycle)
//   ivalid, idata, iword  returned read word and its index
//   idone                 I transfer complete
//   dreq, dwr, daddr      D-cache request, write flag, line address
//   dwdata, dwidx         write word supplied for the index requested
//   dgrant, dvalid, ddata, dword, ddone   D-side equivalents
//   mem_en, mem_wr, mem_addr, mem_din     memory command
//   mem_dout, mem_err     memory read data and error indication
//   err                   sticky error, cleared only by rst
module mem_arb #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq,
  input  logic [12:0] iaddr,
  output logic        igrant,
  output logic        ivalid,
  output logic [15:0] idata,
  output logic [1:0]  iword,
  output logic        idone,
  input  logic        dreq,
  input  logic        dwr,
  input  logic [12:0] daddr,
  input  logic [15:0] dwdata,
  output logic [1:0]  dwidx,
  output logic        dgrant,
  output logic        dvalid,
  output logic [15:0] ddata,
  output logic [1:0]  dword,
  output logic        ddone,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_err,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  typedef struct packed {
    logic       valid;
    owner_t     owner;
    logic [1:0] idx;
  } ret_tag_t;

  // DRAIN re-uses the word counter (it wraps to 0 leaving ISSUE) and must
  // last MEM_LAT-1 cycles; with MEM_LAT=1 the DRAIN state is skipped.
  localparam logic [1:0] DRAIN_LAST = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [12:0] line_q;
  owner_t     owner_q;
  owner_t     last_gnt_q;
  logic       wr_q;
  logic       err_q;
  ret_tag_t   ret_q [MEM_LAT];

  logic     idle;
  logic     issue;
  logic     pick_d;
  logic     do_grant;
  logic     ret_busy;
  ret_tag_t ret_out;

  // ---------------------------------------------------------------------------
  // Arbitration. Grant is suppressed while rst is high so that no grant pulse
  // appears in a reset cycle.
  // ---------------------------------------------------------------------------
  assign idle     = (state_q == S_IDLE);
  assign issue    = (state_q == S_ISSUE);
  assign pick_d   = dreq && (!ireq || (last_gnt_q == OWN_I));
  assign do_grant = idle && !rst && (ireq || dreq);
  assign igrant   = do_grant && !pick_d;
  assign dgrant   = do_grant && pick_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (do_grant) begin
          state_d = S_ISSUE;
          idx_d   = 2'd0;
        end
      end
      S_ISSUE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          if (wr_q || (MEM_LAT == 1)) state_d = S_DONE;
          else                        state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (idx_q == DRAIN_LAST) state_d = S_DONE;
        else                     idx_d   = idx_q + 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ret_busy = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) ret_busy = ret_busy | ret_q[i].valid;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes the shift pipeline shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      line_q     <= '0;
      owner_q    <= OWN_I;
      last_gnt_q <= OWN_I;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      // NOTE: the return pipeline is a handful of flops whose contents must
      // vanish on reset (in-flight words are dropped), so every stage is
      // reset, not only the valid bits.
      for (int i = 0; i < MEM_LAT; i++) ret_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (do_grant) begin
        line_q     <= pick_d ? daddr : iaddr;
        owner_q    <= pick_d ? OWN_D : OWN_I;
        last_gnt_q <= pick_d ? OWN_D : OWN_I;
        wr_q       <= pick_d && dwr;
      end
      if (mem_err && (!idle || ret_busy)) err_q <= 1'b1;
      // A tag is launched for each read issue and emerges MEM_LAT cycles
      // later, aligned with mem_dout.
      ret_q[0] <= '{valid: issue && !wr_q, owner: owner_q, idx: idx_q};
      for (int i = 1; i < MEM_LAT; i++) ret_q[i] <= ret_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Memory command: driven only from registered state, plus the
  // dwdata -> mem_din path during write issue.
  // ---------------------------------------------------------------------------
  assign mem_en   = issue;
  assign mem_wr   = issue && wr_q;
  assign mem_addr = issue ? {line_q, idx_q, 1'b0} : 16'h0000;
  assign dwidx    = mem_wr ? idx_q : 2'd0;
  assign mem_din  = mem_wr ? dwdata : 16'h0000;

  // ---------------------------------------------------------------------------
  // Read return and completion
  // ---------------------------------------------------------------------------
  assign ret_out = ret_q[MEM_LAT-1];
  assign ivalid  = ret_out.valid && (ret_out.owner == OWN_I);
  assign dvalid  = ret_out.valid && (ret_out.owner == OWN_D);
  assign idata   = ivalid ? mem_dout : 16'h0000;
  assign ddata   = dvalid ? mem_dout : 16'h0000;
  assign iword   = ivalid ? ret_out.idx : 2'd0;
  assign dword   = dvalid ? ret_out.idx : 2'd0;
  assign idone   = ivalid && (ret_out.idx == 2'd3);
  assign ddone   = (dvalid && (ret_out.idx == 2'd3)) ||
                   ((state_q == S_DONE) && wr_q);
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb -- scoreboard bench for mem_arb (MEM_LAT=2).
// Stimulus pushes expected grants, memory commands and returned words into
// queues; a negedge monitor pops and compares whenever the DUT shows one.
// Cycle offsets are measured from the most recent grant.
module tb_mem_arb;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, dreq, dwr, mem_err;
  logic [12:0] iaddr, daddr;
  logic [15:0] dwdata, mem_dout;
  logic        igrant, ivalid, idone, dgrant, dvalid, ddone;
  logic [15:0] idata, ddata, mem_addr, mem_din;
  logic [1:0]  iword, dword, dwidx;
  logic        mem_en, mem_wr, err;

  mem_arb #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr), .igrant(igrant), .ivalid(ivalid),
    .idata(idata), .iword(iword), .idone(idone),
    .dreq(dreq), .dwr(dwr), .daddr(daddr), .dwdata(dwdata), .dwidx(dwidx),
    .dgrant(dgrant), .dvalid(dvalid), .ddata(ddata), .dword(dword),
    .ddone(ddone),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_err(mem_err), .err(err)
  );

  always #5 clk = ~clk;

  // D-cache write source: word k of the line is 0xA000+k.
  assign dwdata = 16'hA000 + {14'd0, dwidx};

  // Memory model: read data is a fixed function of the word address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  logic [15:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_wr) ? mem_word(mem_addr) : 16'h0000;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[LAT-1];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [1:0]  widx;
    int          off;
  } mem_exp_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  word;
    logic        done;
    int          off;
  } ret_exp_t;

  logic     gnt_q [$];   // 1 = D side
  mem_exp_t mem_q [$];
  ret_exp_t iret_q [$];
  ret_exp_t dret_q [$];
  int       dwd_q [$];   // write-done offsets

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int gcyc  = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_rd(input logic side_d, input logic [12:0] line,
                         input int nmem, input int nret);
    gnt_q.push_back(side_d);
    for (int k = 0; k < nmem; k++)
      mem_q.push_back('{wr: 1'b0, addr: {line, 2'(k), 1'b0}, din: 16'h0000,
                        widx: 2'd0, off: 1 + k});
    for (int k = 0; k < nret; k++) begin
      ret_exp_t r;
      r = '{data: mem_word({line, 2'(k), 1'b0}), word: 2'(k),
            done: (k == 3), off: 1 + k + LAT};
      if (side_d) dret_q.push_back(r);
      else        iret_q.push_back(r);
    end
  endtask

  task automatic push_wr(input logic [12:0] line);
    gnt_q.push_back(1'b1);
    for (int k = 0; k < 4; k++)
      mem_q.push_back('{wr: 1'b1, addr: {line, 2'(k), 1'b0},
                        din: 16'hA000 + 16'(k), widx: 2'(k), off: 1 + k});
    dwd_q.push_back(5);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic     m_g;
  mem_exp_t m_m;
  ret_exp_t m_r;
  int       m_o;

  always @(negedge clk) begin
    if (igrant || dgrant) begin
      check("gnt_excl", 32'(igrant && dgrant), 32'd0);
      if (gnt_q.size() == 0) check("gnt_extra", 32'd1, 32'd0);
      else begin
        m_g = gnt_q.pop_front();
        check("gnt_side", 32'(dgrant), 32'(m_g));
      end
      gcyc = cyc;
    end
    if (mem_en) begin
      if (mem_q.size() == 0) check("mem_extra", 32'd1, 32'd0);
      else begin
        m_m = mem_q.pop_front();
        check("mem_wr", 32'(mem_wr), 32'(m_m.wr));
        check("mem_addr", 32'(mem_addr), 32'(m_m.addr));
        check("mem_din", 32'(mem_din), 32'(m_m.din));
        check("dwidx", 32'(dwidx), 32'(m_m.widx));
        check("mem_off", 32'(cyc - gcyc), 32'(m_m.off));
      end
    end else begin
      check("dwidx_idle", 32'(dwidx), 32'd0);
    end
    if (ivalid) begin
      if (iret_q.size() == 0) check("ivalid_extra", 32'd1, 32'd0);
      else begin
        m_r = iret_q.pop_front();
        check("idata", 32'(idata), 32'(m_r.data));
        check("iword", 32'(iword), 32'(m_r.word));
        check("idone", 32'(idone), 32'(m_r.done));
        check("iret_off", 32'(cyc - gcyc), 32'(m_r.off));
      end
    end else if (idone) begin
      check("idone_stray", 32'd1, 32'd0);
    end
    if (dvalid) begin
      if (dret_q.size() == 0) check("dvalid_extra", 32'd1, 32'd0);
      else begin
        m_r = dret_q.pop_front();
        check("ddata", 32'(ddata), 32'(m_r.data));
        check("dword", 32'(dword), 32'(m_r.word));
        check("ddone", 32'(ddone), 32'(m_r.done));
        check("dret_off", 32'(cyc - gcyc), 32'(m_r.off));
      end
    end else if (ddone) begin
      if (dwd_q.size() == 0) check("ddone_extra", 32'd1, 32'd0);
      else begin
        m_o = dwd_q.pop_front();
        check("ddone_off", 32'(cyc - gcyc), 32'(m_o));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Wait (at negedges) for an output event: 0 igrant, 1 dgrant, 2 idone, 3 ddone.
  task automatic wait_ev(input int which, input string nm);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      case (which)
        0: if (igrant) return;
        1: if (dgrant) return;
        2: if (idone)  return;
        default: if (ddone) return;
      endcase
    end
    check({"timeout_", nm}, 32'd1, 32'd0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic outs_any();
    return |{igrant, ivalid, idata, iword, idone, dgrant, dvalid, ddata,
             dword, ddone, dwidx, mem_en, mem_wr, mem_addr, mem_din, err};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwr = 1'b0; mem_err = 1'b0;
    iaddr = '0; daddr = '0;
    gap(2);
    @(negedge clk);
    check("reset_outs", 32'(outs_any()), 32'd0);
    gap(1);
    rst = 1'b0;
    gap(1);

    // 1: I line read at 0x0040 -> addresses 0x0200..0x0206.
    push_rd(1'b0, 13'h0040, 4, 4);
    iaddr = 13'h0040; ireq = 1'b1;
    wait_ev(0, "i_gnt");
    gap(1); ireq = 1'b0;
    wait_ev(2, "i_done");
    gap(2);

    // 2: D line write at 0x0001 -> 0xA000..0xA003 to 0x0008..0x000E.
    push_wr(13'h0001);
    daddr = 13'h0001; dwr = 1'b1; dreq = 1'b1;
    wait_ev(1, "d_gnt");
    gap(1); dreq = 1'b0; dwr = 1'b0;
    wait_ev(3, "d_wdone");
    gap(2);

    // 3: both requesting from reset: D, I, D.
    ireq = 1'b1; dreq = 1'b1; dwr = 1'b0;
    iaddr = 13'h0080; daddr = 13'h0300;
    rst = 1'b1;
    push_rd(1'b1, 13'h0300, 4, 4);
    push_rd(1'b0, 13'h0080, 4, 4);
    push_rd(1'b1, 13'h0302, 4, 4);
    gap(2);
    rst = 1'b0;
    fork
      begin
        wait_ev(3, "rr_d1");
        gap(1); dreq = 1'b0;
        gap(1); daddr = 13'h0302; dreq = 1'b1;
        wait_ev(3, "rr_d2");
        gap(1); dreq = 1'b0;
      end
      begin
        wait_ev(2, "rr_i1");
        gap(1); ireq = 1'b0;
      end
    join
    gap(2);

    // 3b: tie with last grant = D -> I first, then the held D write.
    push_rd(1'b0, 13'h0090, 4, 4);
    push_wr(13'h0011);
    iaddr = 13'h0090; daddr = 13'h0011; dwr = 1'b1;
    ireq = 1'b1; dreq = 1'b1;
    fork
      begin
        wait_ev(2, "tie_i");
        gap(1); ireq = 1'b0;
      end
      begin
        wait_ev(3, "tie_d");
        gap(1); dreq = 1'b0; dwr = 1'b0;
      end
    join
    gap(2);

    // 4: D read with mem_err pulsed at T+3.
    push_rd(1'b1, 13'h0123, 4, 4);
    daddr = 13'h0123; dwr = 1'b0; dreq = 1'b1;
    wait_ev(1, "err_gnt");                       // cycle T
    gap(1); dreq = 1'b0;                         // T+1
    gap(2); mem_err = 1'b1;                      // T+3
    @(negedge clk);
    check("err_before", 32'(err), 32'd0);
    gap(1); mem_err = 1'b0;                      // T+4
    @(negedge clk);
    check("err_set", 32'(err), 32'd1);
    wait_ev(3, "err_done");
    gap(3);
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    gap(1); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);
    gap(1); rst = 1'b0;
    gap(2);

    // 5: reset at T+2 of an I read; regrant right after release.
    push_rd(1'b0, 13'h0100, 2, 0);
    iaddr = 13'h0100; ireq = 1'b1;
    wait_ev(0, "rst_gnt");                       // T
    gap(1); ireq = 1'b0;                         // T+1
    gap(1); rst = 1'b1;                          // T+2
    gap(1); iaddr = 13'h0101; ireq = 1'b1;       // T+3
    @(negedge clk);
    check("rst_outs_zero", 32'(outs_any()), 32'd0);
    push_rd(1'b0, 13'h0101, 4, 4);
    gap(1); rst = 1'b0;                          // T+4
    @(negedge clk);
    check("regrant_first", 32'(igrant), 32'd1);
    gap(1); ireq = 1'b0;
    wait_ev(2, "rst_i_done");
    gap(4);

    check("queues_empty",
          32'(gnt_q.size() + mem_q.size() + iret_q.size() + dret_q.size() +
              dwd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Shared-memory arbiter and line-transfer sequencer between the I-cache and D-cache miss paths. Both caches share one single-ported unified backing memory. Each request is one 4-word cache line, read or write. The block accepts requests from both, grants one at a time under round-robin priority, and sequences the four word accesses. It returns read data to the winner with a word index, or pulls write data from it word by word, and signals completion.

## Interface
Parameters:
- MEM_LAT, default 2: cycles from a read issue (mem_en=1, mem_wr=0) to valid mem_dout; legal range 1–4.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ireq  in  1  I-cache line read request; held until igrant
- iaddr  in  13  I-cache line address (byte address [15:3])
- igrant  out  1  one-cycle pulse: I request accepted, iaddr sampled
- ivalid  out  1  read word valid on idata
- idata  out  16  read word
- iword  out  2  index of word on idata
- idone  out  1  one-cycle pulse: I transfer complete
- dreq  in  1  D-cache line request; held until dgrant
- dwr  in  1  1 = line write (writeback), 0 = line read (fill); sampled at dgrant
- daddr  in  13  D-cache line address; sampled at dgrant
- dwdata  in  16  write word selected by dwidx; combinational from D-cache
- dwidx  out  2  index of write word currently requested
- dgrant, dvalid, ddata[16], dword[2], ddone  out  D-side equivalents of the I-side outputs
- mem_en  out  1  memory access enable
- mem_wr  out  1  1 = write
- mem_addr  out  16  word byte address {line, idx, 1'b0}
- mem_din  out  16  write data (= dwdata)
- mem_dout  in  16  read data, MEM_LAT cycles after issue
- mem_err  in  1  memory error
- err  out  1  sticky error, cleared only by rst

## Operation
- States:
  - IDLE: arbitrate; go to ISSUE on grant.
  - ISSUE: four cycles, idx 0..3.
    - After idx 3: DRAIN for reads, DONE for writes.
  - DRAIN: wait for the last read word.
  - DONE: one cycle, then IDLE.
- Arbitration in IDLE:
  - One request pending: that side wins.
  - Both pending: the side not granted last wins.
  - last_gnt register resets to I, so the first tie goes to D.
  - Grant pulse, address capture and dwr capture all happen in the IDLE cycle that transitions.
- Request lines are ignored outside IDLE. A requester must not re-raise its request before its done pulse.
- ISSUE drives:
  - mem_en=1
  - mem_addr={line_q, idx, 1'b0}
  - mem_wr=1 only for D writes.
- D writes: dwidx=idx, mem_din=dwdata in the same cycle. dwidx is 0 outside write ISSUE.
- I requests are always reads.
- Read return:
  - A MEM_LAT-deep shift pipeline of {valid, owner, idx} launches at each issue.
  - At pipeline output: mem_dout is forwarded to the owner's data output with valid and index.
  - All valid outputs for the other side stay 0.
- Done pulse timing:
  - Reads: coincides with the word-3 valid.
  - Writes: in the DONE state.
- err is set if mem_err=1 in any non-IDLE cycle or with a valid in the return pipeline.
- Reset, including mid-transfer:
  - State goes to IDLE; return pipeline cleared; in-flight data dropped; last_gnt=I.
  - All outputs go to 0 in the cycle after the rst edge, and err goes to 0.

## Timing
- Grant at cycle T; issues at T+1..T+4 (idx 0..3).
- Reads: valid word k at T+1+k+MEM_LAT; done at T+4+MEM_LAT.
  - DRAIN lasts MEM_LAT−1 cycles; DONE state overlaps the last return.
  - Next grant is possible at T+5+MEM_LAT, i.e. T+7 for MEM_LAT=2.
- Writes: done at T+5; next grant is possible at T+6.
- No combinational path from ireq/dreq to mem_* outputs.
- Only path from a requester input to mem_*: dwdata → mem_din.

## Test plan
- Reset, then ireq=1, iaddr=13'h0040 (MEM_LAT=2):
  - igrant at T.
  - mem_addr 0x0200, 0x0202, 0x0204, 0x0206 at T+1..T+4.
  - ivalid with iword 0..3 at T+3..T+6; idone at T+6.
- dreq=1, dwr=1, daddr=13'h0001, dwdata=0xA000+dwidx:
  - mem_wr=1 with mem_din 0xA000..0xA003 at addresses 0x0008..0x000E.
  - ddone at T+5; dvalid stays 0.
- ireq and dreq both asserted from reset:
  - Grant order is D, then I, then D while both are held.
  - Each requester drops its request for one cycle after its done.
- Read D transfer with mem_err pulsed at T+3:
  - err=1 from T+4 and stays set.
  - Transfer still completes with ddone at T+6.
  - err clears only after rst.
- rst asserted at T+2 of a read:
  - All outputs are 0 from T+3.
  - No ivalid or idone follows.
  - A new ireq is granted in the first cycle after rst is released.
